// File: rtl/board_pkg.sv
// board_pkg: board clock and debounce timing constants shared by the switch front end.
package board_pkg;
    localparam int CLK_HZ = 100_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    function automatic int cnt_width(input int n);
        return $clog2(n) > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one channel of synchronizer, stability-counter debouncer and rise/fall pulses.
module debounce_bit
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            cnt <= '0;
            clean <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // any agreeing sample restarts the stability window
            if (s2 == clean) begin
                cnt <= '0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else if (cnt == LAST) begin
                clean <= s2;
                cnt <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
                rise <= 1'b0;
                fall <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner: WIDTH independent debounced switch channels with edge pulses.
module switch_conditioner
    import board_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk(clk),
            .rst_n(rst_n),
            .raw(raw[i]),
            .clean(clean[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end
endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Upstream front end for the board's slide switches and pushbuttons. It feeds clean, glitch-free levels into the lab's combinational logic stages, such as the 3-input A/B/C -> Q function driving an LED.
- Per channel: 2-flop synchronizer, then a stability-counter debouncer, then registered rise/fall pulse generation.
- WIDTH independent channels, all on one 100 MHz board clock.

Parameters:
- WIDTH, 3, number of independent input channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronized input must differ from CLEAN before CLEAN updates (10 ms at 100 MHz). Legal range 1..2^24.

Ports:
- CLK  input  1  board clock, all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- RAW  input  WIDTH  raw switch/button levels, asynchronous to CLK, may bounce.
- CLEAN  output  WIDTH  debounced level per channel.
- RISE  output  WIDTH  one-cycle pulse when the CLEAN bit goes 0->1.
- FALL  output  WIDTH  one-cycle pulse when the CLEAN bit goes 1->0.

Behaviour:
- Reset (RST_N low, asynchronous assert, synchronous-to-CLK release by board design):
  - Both sync flops, CNT, CLEAN, RISE and FALL are cleared to 0 immediately, independent of CLK.
- Synchronizer: S1 <= RAW[i]; S2 <= S1. Only S2 is used downstream; RAW is never used elsewhere.
- Per-channel counter CNT, width max(1, $clog2(DEBOUNCE_CYCLES)). Each edge:
  - If S2 == CLEAN[i]: CNT <= 0; RISE/FALL <= 0.
  - Else if CNT == DEBOUNCE_CYCLES-1: CLEAN[i] <= S2; CNT <= 0; RISE[i] <= S2; FALL[i] <= ~S2.
  - Else: CNT <= CNT+1; RISE/FALL <= 0.
- Latency: RAW first sampled at edge k and held steady -> CLEAN and the pulse update at edge k+DEBOUNCE_CYCLES+1.
  - DEBOUNCE_CYCLES=1: update at edge k+2, i.e. synchronizer delay only.
- Pulse alignment:
  - RISE/FALL are high for exactly one cycle, coincident with the first cycle of the new CLEAN value.
  - RISE and FALL are never both high on the same bit.
- Bounce: any cycle with S2 == CLEAN clears CNT, so a glitch shorter than DEBOUNCE_CYCLES produces no CLEAN change and no pulse.
- Counter: never wraps; maximum value is DEBOUNCE_CYCLES-1.
- Channels: fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- Reset mid-count: CNT cleared. After release, a RAW held at 1 produces a RISE once it passes the full debounce, because CLEAN restarts at 0.
- RAW held 1 through reset: the 0->1 RISE after release is intended behaviour (power-on edge).
- No combinational path from RAW to any output.

Decomposition:
- Package board_pkg:
  - CLK_HZ = 100_000_000.
  - DEBOUNCE_MS = 10.
  - Derived constant DEFAULT_DEBOUNCE_CYCLES = CLK_HZ/1000*DEBOUNCE_MS.
  - Function cnt_width(n) returning max(1, $clog2(n)).
- Sub-module debounce_bit: one channel, holding the sync pair, counter, CLEAN bit and pulse bits. Parameter DEBOUNCE_CYCLES.
- switch_conditioner is a generate loop of WIDTH debounce_bit instances.

Test Plan (WIDTH=3, DEBOUNCE_CYCLES=4 unless noted):
- Reset: RST_N=0 with RAW=3'b111, asynchronously and mid-cycle -> CLEAN=000, RISE=000, FALL=000 before the next CLK edge.
- Clean rise: RAW[0] 0->1 before edge 0, held -> CLEAN[0]=1 and RISE[0]=1 after edge 5. RISE[0]=0 after edge 6. FALL stays 0.
- Bounce reject: RAW[1] toggled 1,0,1,0 on successive cycles, then held 0 -> CLEAN[1], RISE[1] and FALL[1] remain 0 throughout.
- Short glitch: RAW[2] high for 3 cycles, then low -> no CLEAN change. RAW[2] high for 4+ cycles -> RISE[2] pulse once.
- Simultaneous fall: CLEAN=111, then RAW=000 held -> FALL=111 for one cycle and CLEAN=000 on the same edge, 5 edges after first sampling.
- Reset mid-count: RAW[0]=1 held; assert RST_N=0 after 3 cycles for 2 cycles, release -> RISE[0] occurs 5 edges after the first post-release edge. DEBOUNCE_CYCLES=1 variant: update 2 edges after the change.
